// File: rtl/alu_serial_seq.sv
// alu_serial_seq
// Bit-serial ALU sequencer. A WIDTH-bit operation runs through one external
// alu1 slice, one bit per clock, LSB first. The ripple carry is held in a
// flop between bits, and the result word is built up in a shift register.
//
// Optional feature macro: ALU_SERIAL_SEQ_OVF_EN
//   defined   : the MSB carry-in is tracked, ovf is driven, and SLT uses
//               SUM_MSB ^ ovf (signed compare)
//   undefined : ovf is tied to 0 and SLT uses the raw SUM MSB
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, a, b, aluop    request and operands, captured in IDLE/DONE
//   slice_a/b/cin/aluop   bit-level drive to the external slice
//   slice_res0..3         slice legs (AND, OR, SUM, 0)
//   slice_cout            slice carry out
//   busy, done            handshake (busy in RUN/FIX, one-cycle done pulse)
//   result, cout, zero    final word, carry out of MSB, result == 0
//   ovf                   signed overflow (only with the macro)

module alu_serial_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       aluop,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_cin,
   output logic [2:0]       slice_aluop,
   input  logic             slice_res0,
   input  logic             slice_res1,
   input  logic             slice_res2,
   input  logic             slice_res3,
   input  logic             slice_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             ovf
);

   localparam int unsigned    CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
   localparam logic [2:0]     OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [2:0]       op;
   logic [CW-1:0]    cnt;
   logic             sum_msb;   // SUM leg at the MSB, used by the SLT fix-up
   logic             c_fin;     // final carry held across FIX
`ifdef ALU_SERIAL_SEQ_OVF_EN
   logic             c_msb;     // carry into the MSB
`endif

   logic             leg_c;
   logic [WIDTH-1:0] res_next_c;

   // Operand shifters empty themselves by shifting in zeros, so the slice
   // bit drives read 0 once a run has finished.
   assign slice_a = a_sh[0];
   assign slice_b = b_sh[0];

   // Leg select and next result word
   always_comb begin
      leg_c = 1'b0;
      case (op[1:0])
         2'b00:   leg_c = slice_res0;
         2'b01:   leg_c = slice_res1;
         2'b10:   leg_c = slice_res2;
         default: leg_c = slice_res3;
      endcase
      res_next_c = {leg_c, res_sh[WIDTH-1:1]};
   end

`ifndef ALU_SERIAL_SEQ_OVF_EN
   assign ovf = 1'b0;
`endif

   // Sequencer: state, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         a_sh        <= '0;
         b_sh        <= '0;
         res_sh      <= '0;
         op          <= 3'b000;
         cnt         <= '0;
         sum_msb     <= 1'b0;
         c_fin       <= 1'b0;
         slice_cin   <= 1'b0;
         slice_aluop <= 3'b000;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         cout        <= 1'b0;
         zero        <= 1'b1;
`ifdef ALU_SERIAL_SEQ_OVF_EN
         c_msb       <= 1'b0;
         ovf         <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_sh        <= a;
                  b_sh        <= b;
                  op          <= aluop;
                  slice_aluop <= aluop;
                  slice_cin   <= aluop[2];   // B-invert implies carry-in of 1
                  cnt         <= '0;
                  busy        <= 1'b1;
                  state       <= S_RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            S_RUN: begin
               res_sh    <= res_next_c;
               a_sh      <= a_sh >> 1;
               b_sh      <= b_sh >> 1;
               slice_cin <= slice_cout;
               cnt       <= cnt + CW'(1);
               if (cnt == LAST) begin
                  slice_cin   <= 1'b0;
                  slice_aluop <= 3'b000;
`ifdef ALU_SERIAL_SEQ_OVF_EN
                  c_msb       <= slice_cin;
`endif
                  if (op == OP_SLT) begin
                     c_fin   <= slice_cout;
                     sum_msb <= slice_res2;
                     state   <= S_FIX;
                  end else begin
                     result <= res_next_c;
                     cout   <= slice_cout;
                     zero   <= (res_next_c == '0);
`ifdef ALU_SERIAL_SEQ_OVF_EN
                     ovf    <= slice_cin ^ slice_cout;
`endif
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end

            S_FIX: begin
`ifdef ALU_SERIAL_SEQ_OVF_EN
               result <= WIDTH'(sum_msb ^ c_msb ^ c_fin);
               zero   <= ~(sum_msb ^ c_msb ^ c_fin);
               ovf    <= c_msb ^ c_fin;
`else
               result <= WIDTH'(sum_msb);
               zero   <= ~sum_msb;
`endif
               cout  <= c_fin;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_DONE;
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq
// Scoreboard bench for alu_serial_seq. A behavioural alu1 slice is attached,
// the driver pushes expected responses computed with whole-word arithmetic,
// and a monitor pops and compares on every done pulse.

module tb_alu_serial_seq;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [2:0]    aluop;
   logic          slice_a, slice_b, slice_cin;
   logic [2:0]    slice_aluop;
   logic          slice_res0, slice_res1, slice_res2, slice_res3, slice_cout;
   logic          busy, done, cout, zero, ovf;
   logic [W-1:0]  result;

   always #5 clk = ~clk;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .aluop(aluop),
      .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
      .slice_aluop(slice_aluop),
      .slice_res0(slice_res0), .slice_res1(slice_res1),
      .slice_res2(slice_res2), .slice_res3(slice_res3),
      .slice_cout(slice_cout),
      .busy(busy), .done(done), .result(result), .cout(cout),
      .zero(zero), .ovf(ovf)
   );

   // One-bit ALU slice: B inverted by aluop[2]
   logic bb1;
   always_comb begin
      bb1        = slice_b ^ slice_aluop[2];
      slice_res0 = slice_a & bb1;
      slice_res1 = slice_a | bb1;
      slice_res2 = slice_a ^ bb1 ^ slice_cin;
      slice_res3 = 1'b0;
      slice_cout = (slice_a & bb1) | (slice_a & slice_cin) | (bb1 & slice_cin);
   end

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         zero;
      logic         ovf;
      int unsigned  cyc;
      int unsigned  nbusy;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Whole-word reference for one operation
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2:0] op);
      exp_t         e;
      logic [W-1:0] bv;
      logic [W:0]   s;
      logic         ov, lt;
      bv = op[2] ? ~mb : mb;
      s  = {1'b0, ma} + {1'b0, bv} + (W+1)'(op[2]);
      ov = (ma[W-1] == bv[W-1]) && (s[W-1] != ma[W-1]);
      case (op[1:0])
         2'b00:   e.res = ma & bv;
         2'b01:   e.res = ma | bv;
         2'b10:   e.res = s[W-1:0];
         default: e.res = '0;
      endcase
      if (op == 3'b111) begin
`ifdef ALU_SERIAL_SEQ_OVF_EN
         lt = s[W-1] ^ ov;
`else
         lt = s[W-1];
`endif
         e.res = W'(lt);
      end
      e.cout  = s[W];
      e.zero  = (e.res == '0);
`ifdef ALU_SERIAL_SEQ_OVF_EN
      e.ovf   = ov;
`else
      e.ovf   = 1'b0;
`endif
      e.nbusy = (op == 3'b111) ? W + 1 : W;
      e.cyc   = 0;
      return e;
   endfunction

   // Monitor: compare every done pulse against the scoreboard head
   int unsigned busy_run = 0;
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
         busy_run = 0;
      end else if (done) begin
         chk("busy_with_done", W'(busy), W'(0));
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            chk("done_cycle", W'(cyc), W'(e.cyc));
            chk("result", result, e.res);
            chk("cout", W'(cout), W'(e.cout));
            chk("zero", W'(zero), W'(e.zero));
            chk("ovf", W'(ovf), W'(e.ovf));
            chk("busy_cycles", W'(busy_run), W'(e.nbusy));
         end
         busy_run = 0;
      end else if (busy) begin
         busy_run++;
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, W'(busy), W'(0));
      chk({tag, "_done"}, W'(done), W'(0));
      chk({tag, "_result"}, result, W'(0));
      chk({tag, "_cout"}, W'(cout), W'(0));
      chk({tag, "_zero"}, W'(zero), W'(1));
      chk({tag, "_ovf"}, W'(ovf), W'(0));
      chk({tag, "_slice"}, W'({slice_a, slice_b, slice_cin, slice_aluop}), W'(0));
   endtask

   // Drive one start pulse at the current negedge
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [2:0] op, input bit expect_accept);
      exp_t e;
      start = 1'b1;
      a     = ia;
      b     = ib;
      aluop = op;
      if (expect_accept) begin
         e     = model(ia, ib, op);
         e.cyc = cyc + ((op == 3'b111) ? W + 2 : W + 1);
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      aluop = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_done();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) return;
      end
      checks++;
      errors++;
      $display("FAIL wait_done: got no done within 200 cycles expected done (cycle %0d)", cyc);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      aluop = 3'b000;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      // Directed operations
      issue(32'd5, 32'd7, 3'b010, 1);                    wait_done(); @(negedge clk);
      issue(32'd3, 32'd5, 3'b110, 1);                    wait_done(); @(negedge clk);
      issue(32'h1234, 32'h1234, 3'b110, 1);              wait_done(); @(negedge clk);
      issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111, 1);    wait_done(); @(negedge clk);
      issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1);    wait_done();
      // Back-to-back: start in the done cycle
      issue(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 1);    wait_done(); @(negedge clk);
      issue(32'h1357_9BDF, 32'h0246_8ACE, 3'b011, 1);    wait_done(); @(negedge clk);
      issue(32'h1357_9BDF, 32'h0246_8ACE, 3'b100, 1);    wait_done(); @(negedge clk);
      issue(32'h1357_9BDF, 32'h0246_8ACE, 3'b101, 1);    wait_done(); @(negedge clk);

      // Start during RUN is ignored
      issue(32'h1111_1111, 32'h2222_2222, 3'b010, 1);
      repeat (9) @(negedge clk);
      issue(32'hDEAD_BEEF, 32'h0000_0001, 3'b001, 0);
      wait_done();
      @(negedge clk);

      // Reset mid-operation: no done, reset values, then normal operation
      issue(32'hAAAA_5555, 32'h5555_AAAA, 3'b010, 0);
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset("midrst");
      repeat (40) @(negedge clk);
      issue(32'd100, 32'd23, 3'b110, 1);                 wait_done(); @(negedge clk);

      // Random operations, mixed back-to-back and gapped
      for (int i = 0; i < 40; i++) begin
         issue(pick(), pick(), 3'($urandom_range(0, 7)), 1);
         wait_done();
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      // Drain the scoreboard
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that runs a full WIDTH-bit ALU operation through a single external `alu1` slice, one bit per clock, LSB first. It holds the operands, feeds the slice, and keeps the ripple carry in a flip-flop between bits. It assembles the result word, then reports result, carry-out and zero through a start/busy/done handshake. It is the area-minimal alternative to instantiating WIDTH slices in the 32-bit ALU.

## Interface

Parameters:
- `WIDTH`, 32, operand/result width in bits (≥2)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when state is IDLE or DONE
- `a`  in  WIDTH  operand A, captured on accepted start
- `b`  in  WIDTH  operand B, captured on accepted start
- `aluop`  in  3  operation, captured on accepted start
- `slice_a`  out  1  current A bit to slice
- `slice_b`  out  1  current B bit to slice
- `slice_cin`  out  1  current carry to slice
- `slice_aluop`  out  3  registered aluop to slice
- `slice_res0`..`slice_res3`  in  1 each  slice legs (AND, OR, SUM, 0)
- `slice_cout`  in  1  slice carry out
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle pulse, result valid
- `result`  out  WIDTH  final result, held until next accepted start
- `cout`  out  1  carry out of MSB
- `zero`  out  1  result == 0
- `ovf`  out  1  signed overflow (see Configuration)

## Operation

- aluop encoding: bit2 = B-invert and initial carry = 1; bits[1:0] select leg (00 res0 AND, 01 res1 OR, 10 res2 SUM, 11 res3). Only 111 (SLT) gets the fix-up step. 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. 011 yields 0; 100/101 yield A AND/OR ~B. All codes are deterministic.
- State machine:
  - IDLE: on start, capture a/b/aluop, set carry = aluop[2], set bit counter = 0, go to RUN.
  - RUN: for each bit, drive slice with A[0], B[0] and carry. Shift result right, inserting the selected leg at the MSB. Shift A and B right. Set carry = slice_cout. Increment counter.
    - The carry into the MSB is saved while counter = WIDTH-1.
    - After bit WIDTH-1, go to FIX if aluop = 111, else to DONE.
  - FIX: result = {WIDTH-1 zeros, lt}. lt = SUM MSB, XORed with overflow when the macro is defined. Then go to DONE.
  - DONE: done = 1 for this single cycle. Accepts start exactly as IDLE does. Otherwise goes to IDLE.
- `cout` = final carry; for SLT it is the carry of the subtraction.
- `zero` is computed from the final result, including the SLT fix-up.
- `ovf` is computed as saved MSB carry-in XOR final carry.
- `start` in RUN/FIX is ignored; operand inputs are don't-care outside accept cycles.
- `slice_*` outputs are 0 in IDLE/DONE.

## Timing

- Start accepted in cycle 0: RUN occupies cycles 1..WIDTH, and done pulses in cycle WIDTH+1 (WIDTH+2 for SLT).
- busy = 1 in RUN and FIX only; busy and done are never both high.
- Back-to-back: start in the DONE cycle is accepted; RUN begins in the next cycle, with zero idle gap.
- result/cout/zero/ovf change only on the DONE entry edge and are stable while done = 1.
- Reset values: state IDLE, busy 0, done 0, result 0, cout 0, zero 1, ovf 0; all slice_* 0.
- Reset mid-operation: the operation is abandoned next edge with no done pulse; outputs take reset values.

## Configuration

- `ALU_SERIAL_SEQ_OVF_EN` defined:
  - the MSB carry-in is tracked;
  - `ovf` is driven;
  - SLT uses SUM_MSB XOR ovf (correct signed compare).
- Not defined:
  - the MSB carry-in register is omitted;
  - `ovf` is tied to 0;
  - SLT uses the raw SUM MSB.

## Test plan

- ADD a=5, b=7, start at cycle 0 -> busy in cycles 1..32, done in cycle 33, result=12, cout=0, zero=0.
- SUB a=3, b=5 -> result=0xFFFFFFFE, cout=0, zero=0. SUB a=b=0x1234 -> result=0, zero=1, cout=1.
- SLT a=0x7FFFFFFF, b=0xFFFFFFFF -> done in cycle 34.
  - With the macro: result=0, ovf=1.
  - Without it: result=1, ovf=0.
- AND/OR a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000 and 0xFFF0FFF0. Back-to-back start in the done cycle gives a second done exactly 33 cycles later.
- start pulsed in cycle 10 of a run with different operands -> ignored, first result unaffected. rst in cycle 15 -> no done pulse, outputs at reset values, next start works normally.
